// File: rtl/store_controller_pkg.sv
// Shared store-side constants: funct3 codes, FSM encoding, byte-enable masks.
package store_controller_pkg;

    localparam int unsigned BE_BITS = 4;
    localparam int unsigned F3_BITS = 3;

    // Store funct3 codes
    localparam logic [F3_BITS-1:0] F3_SB = 3'b000;
    localparam logic [F3_BITS-1:0] F3_SH = 3'b001;
    localparam logic [F3_BITS-1:0] F3_SW = 3'b010;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT1 = 2'd1;
    localparam logic [1:0] ST_BEAT2 = 2'd2;

    // Byte-enable masks for an offset-0 access of each size
    localparam logic [BE_BITS-1:0] BE_B = 4'b0001;
    localparam logic [BE_BITS-1:0] BE_H = 4'b0011;
    localparam logic [BE_BITS-1:0] BE_W = 4'b1111;

    // Size mask for a store funct3; zero marks an illegal encoding
    function automatic logic [BE_BITS-1:0] be_mask(input logic [F3_BITS-1:0] f3);
        case (f3)
            F3_SB:   return BE_B;
            F3_SH:   return BE_H;
            F3_SW:   return BE_W;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/store_controller_if.sv
// Store request and data-memory write bus seen by the store controller.
interface store_if
    import store_controller_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic                 store_valid;
    logic                 store_ready;
    logic [F3_BITS-1:0]   funct3;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata_in;
    logic                 mem_req;
    logic                 mem_ack;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN-1:0]      mem_wdata;
    logic [BE_BITS-1:0]   mem_be;
    logic                 store_done;
    logic                 store_err;
    logic                 store_misaligned;

    // Controller side
    modport slave (
        input  store_valid, funct3, addr, wdata_in, mem_ack,
        output store_ready, mem_req, mem_addr, mem_wdata, mem_be,
               store_done, store_err, store_misaligned
    );

    // Pipeline / memory side
    modport master (
        output store_valid, funct3, addr, wdata_in, mem_ack,
        input  store_ready, mem_req, mem_addr, mem_wdata, mem_be,
               store_done, store_err, store_misaligned
    );
endinterface

// File: rtl/store_controller_align.sv
// Combinational lane alignment: byte enables and data shifted into a two-word window.
module store_align
    import store_controller_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [F3_BITS-1:0]   funct3,
    input  logic [1:0]           off,
    input  logic [XLEN-1:0]      data,
    output logic [2*BE_BITS-1:0] full,
    output logic [2*XLEN-1:0]    wide,
    output logic                 split,
    output logic                 illegal
);

    logic [BE_BITS-1:0] mask;

    // Shift size mask and data by the byte offset; anything past lane 3 spills into beat 2
    always_comb begin
        mask    = be_mask(funct3);
        illegal = (mask == '0);
        full    = {{BE_BITS{1'b0}}, mask} << off;
        wide    = {{XLEN{1'b0}}, data} << {off, 3'b000};
        split   = (full[2*BE_BITS-1:BE_BITS] != '0);
    end

endmodule

// File: rtl/store_controller.sv
// Store controller: turns a decoded store into one or two aligned, byte-enabled memory writes.
module store_controller
    import store_controller_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          ALLOW_SPLIT = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    store_if.slave bus
);

    logic [1:0]           state_q,    state_d;
    logic                 ready_q,    ready_d;
    logic                 req_q,      req_d;
    logic [XLEN-1:0]      addr_q,     addr_d;
    logic [XLEN-1:0]      wdata_q,    wdata_d;
    logic [BE_BITS-1:0]   be_q,       be_d;
    logic [XLEN-1:0]      hi_addr_q,  hi_addr_d;
    logic [XLEN-1:0]      hi_wdata_q, hi_wdata_d;
    logic [BE_BITS-1:0]   hi_be_q,    hi_be_d;
    logic                 split_q,    split_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;
    logic                 mis_q,      mis_d;

    logic [2*BE_BITS-1:0] al_full;
    logic [2*XLEN-1:0]    al_wide;
    logic                 al_split;
    logic                 al_illegal;
    logic [XLEN-1:0]      base_addr;

    store_align #(.XLEN(XLEN)) u_align (
        .funct3  (bus.funct3),
        .off     (bus.addr[1:0]),
        .data    (bus.wdata_in),
        .full    (al_full),
        .wide    (al_wide),
        .split   (al_split),
        .illegal (al_illegal)
    );

    assign base_addr = {bus.addr[XLEN-1:2], 2'b00};

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        hi_addr_d  = hi_addr_q;
        hi_wdata_d = hi_wdata_q;
        hi_be_d    = hi_be_q;
        split_d    = split_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mis_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.store_valid && ready_q) begin
                    if (al_illegal) begin
                        err_d = 1'b1;
                    end else if (al_split && !ALLOW_SPLIT) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d    = ST_BEAT1;
                        ready_d    = 1'b0;
                        req_d      = 1'b1;
                        addr_d     = base_addr;
                        be_d       = al_full[BE_BITS-1:0];
                        wdata_d    = al_wide[XLEN-1:0];
                        hi_addr_d  = base_addr + XLEN'(4);
                        hi_be_d    = al_full[2*BE_BITS-1:BE_BITS];
                        hi_wdata_d = al_wide[2*XLEN-1:XLEN];
                        split_d    = al_split;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus.mem_ack) begin
                    if (split_q) begin
                        state_d = ST_BEAT2;
                        addr_d  = hi_addr_q;
                        be_d    = hi_be_q;
                        wdata_d = hi_wdata_q;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        req_d   = 1'b0;
                        be_d    = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BEAT2: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    req_d   = 1'b0;
                    be_d    = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
                be_d    = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_be_q    <= '0;
            split_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            hi_addr_q  <= hi_addr_d;
            hi_wdata_q <= hi_wdata_d;
            hi_be_q    <= hi_be_d;
            split_q    <= split_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mis_q      <= mis_d;
        end
    end

    assign bus.store_ready      = ready_q;
    assign bus.mem_req          = req_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.mem_be           = be_q;
    assign bus.store_done       = done_q;
    assign bus.store_err        = err_q;
    assign bus.store_misaligned = mis_q;

endmodule

// File: tb/tb_store_controller.sv
// Directed bench for store_controller: vector table plus wait-state, back-to-back,
// reset and no-split corner sequences.
module tb_store_controller;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_failed;

    store_if #(.XLEN(32)) bus1 ();
    store_if #(.XLEN(32)) bus2 ();

    store_controller #(.XLEN(32), .ALLOW_SPLIT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    store_controller #(.XLEN(32), .ALLOW_SPLIT(1'b0)) dut_nosplit (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic        split;
        logic [31:0] a1;
        logic [3:0]  b1;
        logic [31:0] w1;
        logic [31:0] a2;
        logic [3:0]  b2;
        logic [31:0] w2;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        n_tests  = 0;
        n_failed = 0;

        //          f3      addr          data          err   split a1            b1       w1            a2            b2       w2
        vecs[0] = '{3'b010, 32'h00000100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h0,        4'b0000, 32'h0};
        vecs[1] = '{3'b000, 32'h00000103, 32'h000000A5, 1'b0, 1'b0, 32'h00000100, 4'b1000, 32'hA5000000, 32'h0,        4'b0000, 32'h0};
        vecs[2] = '{3'b001, 32'h00000103, 32'h00001234, 1'b0, 1'b1, 32'h00000100, 4'b1000, 32'h34000000, 32'h00000104, 4'b0001, 32'h00000012};
        vecs[3] = '{3'b001, 32'h00000102, 32'hCAFEBEEF, 1'b0, 1'b0, 32'h00000100, 4'b1100, 32'hBEEF0000, 32'h0,        4'b0000, 32'h0};
        vecs[4] = '{3'b000, 32'h00000001, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 4'b0010, 32'h34567800, 32'h0,        4'b0000, 32'h0};
        vecs[5] = '{3'b010, 32'hFFFFFFFD, 32'h11223344, 1'b0, 1'b1, 32'hFFFFFFFC, 4'b1110, 32'h22334400, 32'h00000000, 4'b0001, 32'h00000011};
        vecs[6] = '{3'b011, 32'h00000100, 32'h00000001, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[7] = '{3'b111, 32'h00000104, 32'h00000002, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[8] = '{3'b001, 32'h00000101, 32'h0000ABCD, 1'b0, 1'b0, 32'h00000100, 4'b0110, 32'h00ABCD00, 32'h0,        4'b0000, 32'h0};
        vecs[9] = '{3'b100, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};

        rst = 1'b1;
        bus1.store_valid = 1'b0; bus1.funct3 = '0; bus1.addr = '0; bus1.wdata_in = '0; bus1.mem_ack = 1'b0;
        bus2.store_valid = 1'b0; bus2.funct3 = '0; bus2.addr = '0; bus2.wdata_in = '0; bus2.mem_ack = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req",   32'(bus1.mem_req),     32'd0);
        chk("rst_be",    32'(bus1.mem_be),      32'd0);
        chk("rst_addr",  bus1.mem_addr,         32'd0);
        chk("rst_wdata", bus1.mem_wdata,        32'd0);
        chk("rst_done",  32'(bus1.store_done),  32'd0);
        chk("rst_err",   32'(bus1.store_err),   32'd0);
        chk("rst_ready", 32'(bus1.store_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Table vectors, zero-wait memory (ack held high, ignored while idle)
        bus1.mem_ack = 1'b1;
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            chk("idle_ready", 32'(bus1.store_ready), 32'd1);
            chk("idle_req",   32'(bus1.mem_req),     32'd0);
            bus1.store_valid = 1'b1;
            bus1.funct3      = v.f3;
            bus1.addr        = v.addr;
            bus1.wdata_in    = v.data;
            tick();
            bus1.store_valid = 1'b0;
            if (v.err) begin
                chk("err_pulse", 32'(bus1.store_err),   32'd1);
                chk("err_noreq", 32'(bus1.mem_req),     32'd0);
                chk("err_ready", 32'(bus1.store_ready), 32'd1);
                tick();
                chk("err_clear", 32'(bus1.store_err),   32'd0);
                chk("err_nodone", 32'(bus1.store_done), 32'd0);
                chk("err_noreq2", 32'(bus1.mem_req),    32'd0);
            end else begin
                chk("b1_req",   32'(bus1.mem_req),     32'd1);
                chk("b1_addr",  bus1.mem_addr,         v.a1);
                chk("b1_be",    32'(bus1.mem_be),      32'(v.b1));
                chk("b1_wdata", bus1.mem_wdata,        v.w1);
                chk("b1_busy",  32'(bus1.store_ready), 32'd0);
                tick();
                if (v.split) begin
                    chk("b2_req",   32'(bus1.mem_req),    32'd1);
                    chk("b2_addr",  bus1.mem_addr,        v.a2);
                    chk("b2_be",    32'(bus1.mem_be),     32'(v.b2));
                    chk("b2_wdata", bus1.mem_wdata,       v.w2);
                    chk("b2_nodone", 32'(bus1.store_done), 32'd0);
                    tick();
                end
                chk("done_pulse", 32'(bus1.store_done),  32'd1);
                chk("done_ready", 32'(bus1.store_ready), 32'd1);
                chk("done_noreq", 32'(bus1.mem_req),     32'd0);
                tick();
                chk("done_clear", 32'(bus1.store_done),  32'd0);
            end
        end

        // Split sw at 0x102 with three wait cycles per beat; busy requests ignored
        bus1.mem_ack     = 1'b0;
        bus1.store_valid = 1'b1;
        bus1.funct3      = 3'b010;
        bus1.addr        = 32'h00000102;
        bus1.wdata_in    = 32'hAABBCCDD;
        tick();
        bus1.funct3 = 3'b011;
        for (int c = 0; c < 3; c++) begin
            chk("ws_b1_req",   32'(bus1.mem_req),     32'd1);
            chk("ws_b1_addr",  bus1.mem_addr,         32'h00000100);
            chk("ws_b1_be",    32'(bus1.mem_be),      32'hC);
            chk("ws_b1_wdata", bus1.mem_wdata,        32'hCCDD0000);
            chk("ws_b1_busy",  32'(bus1.store_ready), 32'd0);
            chk("ws_b1_noerr", 32'(bus1.store_err),   32'd0);
            if (c == 2) begin
                bus1.mem_ack     = 1'b1;
                bus1.store_valid = 1'b0;
            end
            tick();
        end
        bus1.mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ws_b2_req",   32'(bus1.mem_req),     32'd1);
            chk("ws_b2_addr",  bus1.mem_addr,         32'h00000104);
            chk("ws_b2_be",    32'(bus1.mem_be),      32'h3);
            chk("ws_b2_wdata", bus1.mem_wdata,        32'h0000AABB);
            chk("ws_b2_busy",  32'(bus1.store_ready), 32'd0);
            chk("ws_b2_nodone", 32'(bus1.store_done), 32'd0);
            if (c == 2) bus1.mem_ack = 1'b1;
            tick();
        end
        chk("ws_done",  32'(bus1.store_done),  32'd1);
        chk("ws_noerr", 32'(bus1.store_err),   32'd0);
        tick();
        chk("ws_done_clear", 32'(bus1.store_done), 32'd0);

        // Back-to-back: new request accepted in the store_done cycle
        bus1.store_valid = 1'b1;
        bus1.funct3      = 3'b010;
        bus1.addr        = 32'h00000200;
        bus1.wdata_in    = 32'h01020304;
        tick();
        bus1.store_valid = 1'b0;
        chk("bb_a_addr", bus1.mem_addr, 32'h00000200);
        tick();
        chk("bb_done",  32'(bus1.store_done),  32'd1);
        chk("bb_ready", 32'(bus1.store_ready), 32'd1);
        bus1.store_valid = 1'b1;
        bus1.funct3      = 3'b000;
        bus1.addr        = 32'h00000204;
        bus1.wdata_in    = 32'h00000055;
        tick();
        bus1.store_valid = 1'b0;
        chk("bb_b_req",   32'(bus1.mem_req), 32'd1);
        chk("bb_b_addr",  bus1.mem_addr,     32'h00000204);
        chk("bb_b_be",    32'(bus1.mem_be),  32'h1);
        chk("bb_b_wdata", bus1.mem_wdata,    32'h00000055);
        tick();
        chk("bb_b_done", 32'(bus1.store_done), 32'd1);
        tick();

        // Reset asserted while in beat 2
        bus1.mem_ack     = 1'b0;
        bus1.store_valid = 1'b1;
        bus1.funct3      = 3'b001;
        bus1.addr        = 32'h00000103;
        bus1.wdata_in    = 32'h00001234;
        tick();
        bus1.store_valid = 1'b0;
        chk("rb_b1_be", 32'(bus1.mem_be), 32'h8);
        bus1.mem_ack = 1'b1;
        tick();
        bus1.mem_ack = 1'b0;
        chk("rb_b2_req", 32'(bus1.mem_req), 32'd1);
        chk("rb_b2_be",  32'(bus1.mem_be),  32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_async_req",   32'(bus1.mem_req),     32'd0);
        chk("rb_async_be",    32'(bus1.mem_be),      32'd0);
        chk("rb_async_ready", 32'(bus1.store_ready), 32'd1);
        tick();
        rst = 1'b0;
        bus1.mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rb_post_req",   32'(bus1.mem_req),     32'd0);
            chk("rb_post_done",  32'(bus1.store_done),  32'd0);
            chk("rb_post_ready", 32'(bus1.store_ready), 32'd1);
        end

        // Split disabled: misaligned stores flagged, aligned ones still written
        bus2.mem_ack     = 1'b1;
        bus2.store_valid = 1'b1;
        bus2.funct3      = 3'b010;
        bus2.addr        = 32'h00000101;
        bus2.wdata_in    = 32'h11111111;
        tick();
        bus2.store_valid = 1'b0;
        chk("ns_mis_pulse", 32'(bus2.store_misaligned), 32'd1);
        chk("ns_mis_noreq", 32'(bus2.mem_req),          32'd0);
        chk("ns_mis_ready", 32'(bus2.store_ready),      32'd1);
        chk("ns_mis_noerr", 32'(bus2.store_err),        32'd0);
        tick();
        chk("ns_mis_clear", 32'(bus2.store_misaligned), 32'd0);
        chk("ns_mis_nodone", 32'(bus2.store_done),      32'd0);
        chk("ns_mis_noreq2", 32'(bus2.mem_req),         32'd0);
        bus2.store_valid = 1'b1;
        bus2.funct3      = 3'b001;
        bus2.addr        = 32'h00000102;
        bus2.wdata_in    = 32'h00005678;
        tick();
        bus2.store_valid = 1'b0;
        chk("ns_al_nomis", 32'(bus2.store_misaligned), 32'd0);
        chk("ns_al_req",   32'(bus2.mem_req),          32'd1);
        chk("ns_al_be",    32'(bus2.mem_be),           32'hC);
        chk("ns_al_wdata", bus2.mem_wdata,             32'h56780000);
        tick();
        chk("ns_al_done",  32'(bus2.store_done),       32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/store_controller.md
Name: store_controller

Overview:
- Store-side counterpart of the load decode path. Accepts a decoded store (funct3, byte address, rs2 data) from the execute stage.
- Produces byte-enabled, lane-aligned write transactions to the data memory over a req/ack handshake.
- Splits misaligned halfword/word stores into two aligned word writes.
- Sits between the EX/MEM pipeline register and the data memory; stalls the pipeline via `store_ready` while busy.

Parameters:
- XLEN, 32, data and address width in bits.
- ALLOW_SPLIT, 1. 1 = misaligned stores are split into two beats. 0 = misaligned stores raise `store_misaligned` and perform no write.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- store_valid  input  1  store request from EX/MEM
- store_ready  output  1  high when a request can be accepted
- funct3  input  3  000 = sb, 001 = sh, 010 = sw
- addr  input  XLEN  byte address
- wdata_in  input  XLEN  rs2 value; low bytes are significant
- mem_req  output  1  write request to data memory
- mem_ack  input  1  memory accepted the current beat
- mem_addr  output  XLEN  word-aligned address, bits [1:0] = 00
- mem_wdata  output  XLEN  lane-aligned write data
- mem_be  output  4  byte enables; bit i selects lane [8i+7:8i]
- store_done  output  1  one-cycle pulse when the store fully completes
- store_err  output  1  one-cycle pulse for an illegal funct3
- store_misaligned  output  1  one-cycle pulse, only when ALLOW_SPLIT = 0

Behaviour:
- States: IDLE, BEAT1, BEAT2.
- `store_ready` = (state == IDLE).
- A request is accepted when `store_valid && store_ready`. On acceptance, register funct3, addr, wdata_in and off = addr[1:0].
- Size mask: sb = 0001, sh = 0011, sw = 1111.
- Compute full = {4'b0, mask} << off, an 8-bit value.
- Compute wide = {32'b0, data} << (8*off), a 64-bit value.
- Split condition: split = (full[7:4] != 0).
- Beat 1:
  - mem_addr = {addr[XLEN-1:2], 2'b00}
  - mem_be = full[3:0]
  - mem_wdata = wide[31:0]
- Beat 2:
  - mem_addr = beat-1 address + 4; wraps modulo 2^XLEN
  - mem_be = full[7:4]
  - mem_wdata = wide[63:32]
- Illegal funct3 (011..111) on accept:
  - `store_err` pulses in the next cycle.
  - State stays IDLE; no `mem_req`; no `store_done`.
- Misaligned store (split) with ALLOW_SPLIT = 0:
  - `store_misaligned` pulses in the next cycle.
  - No write; state stays IDLE.
- Otherwise, accept moves the block to BEAT1.
- In BEAT1 and BEAT2, `mem_req` = 1 and mem_addr/mem_be/mem_wdata are registered and held stable until `mem_ack`.
- BEAT1 with mem_ack:
  - If split, go to BEAT2.
  - Otherwise, go to IDLE and pulse `store_done` in the next cycle.
- BEAT2 with mem_ack: go to IDLE and pulse `store_done` in the next cycle.
- Latency with zero-wait memory (ack in the same cycle as req):
  - accept at cycle N
  - `mem_req` at N+1
  - `store_done` at N+2 (N+3 for a split store)
- `store_ready` rises in the same cycle as `store_done`. A new request may be accepted in that cycle.
- `mem_ack` while `mem_req` = 0 is ignored.
- `store_valid` while busy is ignored. The upstream stage holds the request until `store_ready`.
- Reset, including mid-transaction: state = IDLE immediately. Also:
  - mem_req, mem_be, store_done, store_err, store_misaligned = 0
  - mem_addr, mem_wdata = 0
  - no partial beat 2 is ever issued after reset

Decomposition:
- Shared package (alongside the load-side defines):
  - store funct3 constants (sb/sh/sw)
  - state encoding
  - byte-enable masks (BE_B, BE_H, BE_W)
- One sub-module, `store_align`: purely combinational. Takes funct3, off and data; outputs full[7:0], wide[63:0], split and illegal.
- The FSM and registers live in `store_controller`.

Test Plan:
- Aligned sw: addr 0x100, data 0xDEADBEEF, ack immediately -> one beat: mem_addr 0x100, be 1111, wdata 0xDEADBEEF; `store_done` at N+2.
- sb to lane 3: addr 0x103, data 0x000000A5 -> one beat: addr 0x100, be 1000, wdata 0xA5000000.
- Split sh: addr 0x103, data 0x00001234 ->
  - beat 1: addr 0x100, be 1000, wdata 0x34000000
  - beat 2: addr 0x104, be 0001, wdata 0x00000012
  - single `store_done`
- Split sw with wait states: addr 0x102, data 0xAABBCCDD, ack delayed 3 cycles per beat ->
  - beat 1: addr 0x100, be 1100, wdata 0xCCDD0000, held stable
  - beat 2: addr 0x104, be 0011, wdata 0x0000AABB
  - `store_ready` low throughout
- Illegal funct3 = 011 -> `store_err` pulses once; `mem_req` never asserts; `store_ready` stays 1. With ALLOW_SPLIT = 0, sw at 0x101 -> `store_misaligned` pulses and no write occurs.
- Reset asserted in BEAT2 -> `mem_req` and `mem_be` drop asynchronously; after release the state is IDLE, `store_ready` = 1, and no `store_done` is issued.
